// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder built from a one-bit full-adder cell and a
// registered carry. Adds a + b + cin LSB first, one bit per clock, with a
// valid/ready load handshake upstream and a valid/ready result handshake
// downstream.
// Optional feature: define SERIAL_ADDER_OVF_EN to add the signed-overflow
// output ovf (carry into MSB XOR carry out of MSB), held with the result.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             done_valid,
  input  logic             done_ready
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // One-bit full-adder cell: returns {carry_out, sum_bit}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    full_add = {(x & y) | ((x ^ y) & ci), x ^ y ^ ci};
  endfunction

  state_t           state_r;
  state_t           state_nx_s;
  logic             start_ready_r;
  logic             start_ready_nx_s;
  logic             done_valid_r;
  logic             done_valid_nx_s;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] sum_r;
  logic [WIDTH-1:0] sum_nx_s;
  logic             carry_r;
  logic             cout_r;
  logic [CW-1:0]    cnt_r;
  logic [1:0]       fa_s;
  logic             bit_s;
  logic             carry_nx_s;
  logic             last_bit_s;
  logic             accept_s;
  logic             run_s;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_r;
`endif

  assign fa_s       = full_add(a_sh_r[0], b_sh_r[0], carry_r);
  assign bit_s      = fa_s[0];
  assign carry_nx_s = fa_s[1];
  assign last_bit_s = (cnt_r == LAST_CNT);
  assign accept_s   = (state_r == ST_IDLE) && start_valid;
  assign run_s      = (state_r == ST_RUN);

  // Result shift: old bits move toward the LSB, the new sum bit enters at the MSB.
  always_comb begin
    sum_nx_s = sum_r >> 1;
    sum_nx_s[WIDTH-1] = bit_s;
  end

  // Next-state logic: IDLE -> RUN on accept, RUN -> DONE on the last bit, DONE -> IDLE on result handshake.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_valid) state_nx_s = ST_RUN;
        else             state_nx_s = ST_IDLE;
      end
      ST_RUN: begin
        if (last_bit_s) state_nx_s = ST_DONE;
        else            state_nx_s = ST_RUN;
      end
      ST_DONE: begin
        if (done_ready) state_nx_s = ST_IDLE;
        else            state_nx_s = ST_DONE;
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Output decode of the upcoming state so the handshake outputs come straight from flops.
  always_comb begin
    start_ready_nx_s = 1'b0;
    done_valid_nx_s  = 1'b0;
    case (state_nx_s)
      ST_IDLE: begin
        start_ready_nx_s = 1'b1;
        done_valid_nx_s  = 1'b0;
      end
      ST_RUN: begin
        start_ready_nx_s = 1'b0;
        done_valid_nx_s  = 1'b0;
      end
      ST_DONE: begin
        start_ready_nx_s = 1'b0;
        done_valid_nx_s  = 1'b1;
      end
      default: begin
        start_ready_nx_s = 1'b0;
        done_valid_nx_s  = 1'b0;
      end
    endcase
  end

  // State and handshake-output registers; reset returns to IDLE ready to accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      start_ready_r <= 1'b1;
      done_valid_r  <= 1'b0;
    end else begin
      state_r       <= state_nx_s;
      start_ready_r <= start_ready_nx_s;
      done_valid_r  <= done_valid_nx_s;
    end
  end

  // Datapath: load operands on accept, then one full-adder step per RUN edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_sh_r  <= '0;
      b_sh_r  <= '0;
      sum_r   <= '0;
      carry_r <= 1'b0;
      cout_r  <= 1'b0;
      cnt_r   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_r   <= 1'b0;
`endif
    end else if (accept_s) begin
      a_sh_r  <= a;
      b_sh_r  <= b;
      sum_r   <= '0;
      carry_r <= cin;
      cout_r  <= 1'b0;
      cnt_r   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_r   <= 1'b0;
`endif
    end else if (run_s) begin
      a_sh_r  <= a_sh_r >> 1;
      b_sh_r  <= b_sh_r >> 1;
      sum_r   <= sum_nx_s;
      carry_r <= carry_nx_s;
      cnt_r   <= cnt_r + CW'(1);
      if (last_bit_s) begin
        cout_r <= carry_nx_s;
`ifdef SERIAL_ADDER_OVF_EN
        // carry_r is the carry into the MSB on the last step; for WIDTH=1 it is cin.
        ovf_r  <= carry_r ^ carry_nx_s;
`endif
      end
    end
  end

  assign start_ready = start_ready_r;
  assign done_valid  = done_valid_r;
  assign sum         = sum_r;
  assign cout        = cout_r;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf         = ovf_r;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder: a WIDTH=8 and a WIDTH=1 instance, randomized and
// directed operands, expected results queued at accept time and checked by an
// independent monitor against an arithmetic reference model.
`timescale 1ns/1ps
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       sv8, sr8, cin8, cout8, dv8, dr8;
  logic [7:0] a8, b8, sum8;
  logic       sv1, sr1, a1, b1, cin1, sum1, cout1, dv1, dr1;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf8, ovf1;
`endif

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start_valid(sv8), .start_ready(sr8),
    .a(a8), .b(b8), .cin(cin8), .sum(sum8), .cout(cout8),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf(ovf8),
`endif
    .done_valid(dv8), .done_ready(dr8)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .reset(reset), .start_valid(sv1), .start_ready(sr1),
    .a(a1), .b(b1), .cin(cin1), .sum(sum1), .cout(cout1),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf(ovf1),
`endif
    .done_valid(dv1), .done_ready(dr1)
  );

  typedef struct {
    logic [63:0] s;
    logic        c;
    logic        o;
  } exp_t;

  exp_t q8[$];
  exp_t q1[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int drv_to = 0;
  bit mon_en = 1'b0;
  bit fin = 1'b0;

  // Reference: plain unsigned and signed arithmetic on w-bit operands.
  function automatic exp_t model(input int w, input longint unsigned av,
                                 input longint unsigned bv, input bit ci);
    exp_t e;
    longint unsigned tot, m;
    longint sa, sb, sr, half;
    m    = 64'd1 << w;
    tot  = av + bv + 64'(ci);
    e.s  = tot % m;
    e.c  = (tot >= m);
    half = longint'(m / 2);
    sa   = (av >= m / 2) ? longint'(av) - longint'(m) : longint'(av);
    sb   = (bv >= m / 2) ? longint'(bv) - longint'(m) : longint'(bv);
    sr   = sa + sb + longint'(ci);
    e.o  = (sr > half - 1) || (sr < -half);
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor/scoreboard state (written only by the monitor process)
  bit  busy8 = 1'b0, busy1 = 1'b0;
  int  acc8 = 0, acc1 = 0;
  bit  prev_rst = 1'b1;
  int  to_seen = 0;
  bit  fin_done = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: checks handshake timing against a cycle model and results against the queue.
  always @(negedge clk) begin : mon
    exp_t e;
    bit   dvx8, dvx1;
    dvx8 = busy8 && (cyc - acc8 >= 8);
    dvx1 = busy1 && (cyc - acc1 >= 1);
    if (mon_en) begin
      if (drv_to != to_seen) begin
        chk("driver_timeout", 64'(drv_to), 64'(to_seen));
        to_seen = drv_to;
      end
      if (prev_rst) begin
        chk("rst_sum8", 64'(sum8), 64'd0);
        chk("rst_cout8", 64'(cout8), 64'd0);
        chk("rst_sum1", 64'(sum1), 64'd0);
        chk("rst_cout1", 64'(cout1), 64'd0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("rst_ovf8", 64'(ovf8), 64'd0);
        chk("rst_ovf1", 64'(ovf1), 64'd0);
`endif
      end
      chk("start_ready8", 64'(sr8), 64'(!busy8));
      chk("done_valid8", 64'(dv8), 64'(dvx8));
      chk("start_ready1", 64'(sr1), 64'(!busy1));
      chk("done_valid1", 64'(dv1), 64'(dvx1));
      if (dv8) begin
        chk("pending8", 64'(q8.size() != 0), 64'd1);
        if (q8.size() != 0) begin
          e = q8[0];
          chk("sum8", 64'(sum8), e.s);
          chk("cout8", 64'(cout8), 64'(e.c));
`ifdef SERIAL_ADDER_OVF_EN
          chk("ovf8", 64'(ovf8), 64'(e.o));
`endif
          if (dr8) void'(q8.pop_front());
        end
      end
      if (dv1) begin
        chk("pending1", 64'(q1.size() != 0), 64'd1);
        if (q1.size() != 0) begin
          e = q1[0];
          chk("sum1", 64'(sum1), e.s);
          chk("cout1", 64'(cout1), 64'(e.c));
`ifdef SERIAL_ADDER_OVF_EN
          chk("ovf1", 64'(ovf1), 64'(e.o));
`endif
          if (dr1) void'(q1.pop_front());
        end
      end
      if (fin && !fin_done) begin
        chk("q8_drained", 64'(q8.size()), 64'd0);
        chk("q1_drained", 64'(q1.size()), 64'd0);
        fin_done = 1'b1;
      end
    end
    // advance the model to the state after the coming edge
    if (reset) busy8 = 1'b0;
    else if (!busy8 && sv8) begin busy8 = 1'b1; acc8 = cyc + 1; end
    else if (dvx8 && dr8) busy8 = 1'b0;
    if (reset) busy1 = 1'b0;
    else if (!busy1 && sv1) begin busy1 = 1'b1; acc1 = cyc + 1; end
    else if (dvx1 && dr1) busy1 = 1'b0;
    prev_rst = reset;
  end

  // Present one WIDTH=8 operation and wait (bounded) for it to be accepted.
  task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic cv, input bit push);
    int n;
    n = 0;
    a8 = av; b8 = bv; cin8 = cv; sv8 = 1'b1;
    @(negedge clk);
    while (!sr8 && n < 100) begin @(negedge clk); n++; end
    if (!sr8) drv_to++;
    else if (push) q8.push_back(model(8, av, bv, cv));
    @(posedge clk); #1;
    sv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
  endtask

  // Wait (bounded) until every queued WIDTH=8 result has been taken.
  task automatic wait8(input bit rnd);
    int n;
    n = 0;
    while (q8.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      if (rnd) dr8 = 1'($urandom_range(0, 1));
      n++;
    end
    if (q8.size() != 0) drv_to++;
    dr8 = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    reset = 1'b1;
    sv8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0; dr8 = 1'b1;
    sv1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0; dr1 = 1'b1;
    repeat (2) @(posedge clk);
    #1 mon_en = 1'b1;
    @(posedge clk); #1 reset = 1'b0;

    // directed operations
    op8(8'h35, 8'h4A, 1'b0, 1'b1); wait8(1'b0);
    op8(8'hFF, 8'h01, 1'b0, 1'b1); wait8(1'b0);
    op8(8'hFF, 8'hFF, 1'b1, 1'b1); wait8(1'b0);
    op8(8'h7F, 8'h01, 1'b0, 1'b1); wait8(1'b0);
    op8(8'h80, 8'h80, 1'b0, 1'b1); wait8(1'b0);
    op8(8'h00, 8'h00, 1'b1, 1'b1); wait8(1'b0);

    // backpressure in DONE while upstream inputs toggle
    dr8 = 1'b0;
    op8(8'h5C, 8'hA7, 1'b1, 1'b1);
    n = 0;
    while (!dv8 && n < 30) begin @(posedge clk); #1; n++; end
    if (!dv8) drv_to++;
    repeat (5) begin
      @(posedge clk); #1;
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); sv8 = 1'($urandom);
    end
    sv8 = 1'b0; dr8 = 1'b1;
    wait8(1'b0);

    // reset at RUN edge E3: no result may appear
    op8(8'hAA, 8'h55, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    op8(8'h01, 8'h02, 1'b0, 1'b1); wait8(1'b0);

    // random single operations with random downstream stalls
    for (int i = 0; i < 25; i++) begin
      op8(8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
      wait8(1'b1);
    end

    // back-to-back with start_valid and done_ready held high
    dr8 = 1'b1; sv8 = 1'b1;
    for (int i = 0; i < 130; i++) begin
      @(negedge clk);
      if (sr8) q8.push_back(model(8, a8, b8, cin8));
      @(posedge clk); #1;
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    end
    sv8 = 1'b0;
    wait8(1'b0);

    // WIDTH=1 back-to-back, starting with 1+1+1
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; dr1 = 1'b1; sv1 = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (sr1) q1.push_back(model(1, a1, b1, cin1));
      @(posedge clk); #1;
      a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
    end
    sv1 = 1'b0;
    n = 0;
    while (q1.size() != 0 && n < 20) begin @(posedge clk); #1; n++; end
    if (q1.size() != 0) drv_to++;

    repeat (2) @(posedge clk);
    #1 fin = 1'b1;
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
